load_access_unit: RTL
=====================

# load_access_unit

Sequential load unit sitting between the execute stage and the data-memory port of the pipelined core. It accepts one load request at a time and issues one or two word-aligned memory beats over a req/gnt/rvalid bus. It then extracts and sign- or zero-extends the addressed bytes and returns the result over a valid/ready response channel. It generalises the single-cycle load extension logic to XLEN 32/64 (adds LD/LWU), handshaked memory, and optional misaligned-access splitting.

## Interface
Parameters:
- XLEN, 32, data width; legal values 32 or 64
- ADDR_W, 32, byte-address width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- req_valid_i  in  1  load request valid
- req_ready_o  out  1  unit can accept a request (high only in IDLE)
- req_addr_i  in  ADDR_W  byte address
- req_funct3_i  in  3  RISC-V load funct3
- req_rd_i  in  5  destination register tag, returned unchanged
- mem_req_o  out  1  memory beat request
- mem_gnt_i  in  1  memory accepted beat
- mem_addr_o  out  ADDR_W  beat address, XLEN/8-aligned (low log2(XLEN/8) bits zero)
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  XLEN  read data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_data_o  out  XLEN  extended load result
- rsp_rd_o  out  5  tag of the response
- rsp_fault_o  out  1  illegal funct3 or disallowed misalignment

## Operation
- funct3 decode: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. When XLEN=64, also 011 LD and 110 LWU. Every other code is illegal.
- Size S bytes ∈ {1,2,4,8}; offset = addr mod (XLEN/8). Signed ops replicate the top extracted bit; unsigned ops zero-fill up to XLEN.
- FSM states: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready_o=1. On req_valid_i, latch addr/funct3/rd.
  - Illegal funct3 goes to RESP with fault=1 and data=0. No memory access.
  - Otherwise the request goes to REQ0.
- REQ0/REQ1: mem_req_o=1 and mem_addr_o holds the beat address until mem_gnt_i. On grant, go to WAIT0/WAIT1.
- WAIT0/WAIT1: capture mem_rdata_i on mem_rvalid_i.
  - From WAIT0, a split access goes to REQ1; otherwise go to RESP.
  - From WAIT1, go to RESP.
- Split condition: offset+S > XLEN/8.
  - Beat0 = aligned addr. Beat1 = aligned addr + XLEN/8, computed modulo 2^ADDR_W (wraps at the top of the address space).
- Assembly: {beat1, beat0} (2·XLEN bits) is shifted right by 8·offset. The low S bytes are then extended. Non-split accesses use only beat0.
- RESP: rsp_valid_o=1 with data, rd and fault held stable until rsp_ready_i. Then go to IDLE.
- mem_rvalid_i is ignored outside WAIT0/WAIT1. mem_gnt_i is ignored when mem_req_o=0.
- Reset values: all outputs 0 except req_ready_o=1. State is IDLE.
- Reset mid-operation: return to IDLE next edge, drop mem_req_o immediately, discard captured beats. A late rvalid arriving in IDLE is ignored.

## Timing
- Request accepted at edge 0. mem_req_o is high in cycle 1.
- Aligned load with same-cycle grant and next-cycle rvalid: rsp_valid_o in cycle 3 (3-cycle minimum latency).
- Split load minimum latency: 5 cycles. Illegal/faulting load: rsp_valid_o in cycle 1.
- Each memory stall cycle (no gnt/rvalid) adds one cycle. Each response stall cycle (rsp_ready_i=0) holds RESP and keeps req_ready_o=0.
- No request/response overlap: throughput is one load per response handshake.

## Configuration
- LOAD_MISALIGNED_EN defined: misaligned loads are split into two beats as above.
- LOAD_MISALIGNED_EN undefined: any access with offset mod S ≠ 0 goes to RESP with fault=1 and data=0 (1-cycle latency). REQ1/WAIT1 are removed.

## Structure
- Package load_pkg holds:
  - the funct3 localparams (LB..LWU)
  - the state enum
  - a size-decode function (funct3 → S, legality per XLEN)
- Sub-module lane_extract_extend: combinational, parametrised by XLEN. Inputs are the 2·XLEN-bit beat pair, offset and funct3; output is the extended XLEN result. The FSM instantiates it once.

## Test plan
- XLEN=32, LB at 0x1003, rdata=0x80FF_0000 → data 0xFFFF_FF80, fault=0, 3 cycles.
- XLEN=32, LHU at 0x1002, rdata=0xBEEF_1234 → data 0x0000_BEEF.
- XLEN=32 with LOAD_MISALIGNED_EN, LW at 0x1002, beats 0xAAAA_1111 / 0x2222_BBBB:
  - mem addrs 0x1000 then 0x1004
  - data 0xBBBB_AAAA, 5 cycles
- Same LW with the macro undefined → fault=1, data 0, no mem_req_o, rsp in cycle 1.
- XLEN=64, LWU at 0x8, rdata=0xFFFF_FFFF_8000_0001 → 0x0000_0000_8000_0001. Then funct3=111 → fault=1.
- Backpressure and reset:
  - rsp_ready_i=0 for 4 cycles → rsp held stable and req_ready_o=0.
  - rst_ni low during WAIT0 with a later rvalid → IDLE, no response emitted.

Source files
------------

// File: rtl/load_pkg.sv
// Shared definitions for the load access unit: funct3 codes, FSM states and
// the funct3 -> access-size decode used by the FSM.
package load_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_WAIT0,
    S_REQ1,
    S_WAIT1,
    S_RESP
  } load_state_e;

  typedef struct packed {
    logic       legal;
    logic [3:0] size;
  } size_dec_t;

  // LD and LWU only exist on a 64-bit datapath.
  function automatic size_dec_t decode_size(input logic [2:0] funct3,
                                            input logic       is_rv64);
    size_dec_t d;
    d.legal = 1'b0;
    d.size  = 4'd1;
    case (funct3)
      F3_LB, F3_LBU: begin
        d.legal = 1'b1;
        d.size  = 4'd1;
      end
      F3_LH, F3_LHU: begin
        d.legal = 1'b1;
        d.size  = 4'd2;
      end
      F3_LW: begin
        d.legal = 1'b1;
        d.size  = 4'd4;
      end
      F3_LD: begin
        d.legal = is_rv64;
        d.size  = 4'd8;
      end
      F3_LWU: begin
        d.legal = is_rv64;
        d.size  = 4'd4;
      end
      default: begin
        d.legal = 1'b0;
        d.size  = 4'd1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lane_extract_extend.sv
// Combinational byte-lane extraction and sign/zero extension of a load result
// taken from a pair of memory beats.
module lane_extract_extend
  import load_pkg::*;
#(
  parameter  int XLEN  = 32,
  localparam int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2*XLEN-1:0] beat_pair,
  input  logic [OFF_W-1:0]  offset,
  input  logic [2:0]        funct3,
  output logic [XLEN-1:0]   data
);

  logic [XLEN-1:0] low;
  logic [XLEN-1:0] keep_mask;
  logic [XLEN-1:0] top_mask;
  logic [6:0]      nbits;
  logic            sign;

  // keep_mask covers the loaded bytes; top_mask isolates their top bit.
  always_comb begin
    low       = XLEN'(beat_pair >> {offset, 3'b000});
    nbits     = 7'd8 << funct3[1:0];
    keep_mask = ~({XLEN{1'b1}} << nbits);
    top_mask  = keep_mask ^ (keep_mask >> 1);
    sign      = ~funct3[2] & (|(low & top_mask));
    data      = (low & keep_mask) | ({XLEN{sign}} & ~keep_mask);
  end

endmodule

// File: rtl/load_access_unit.sv
// Handshaked load unit: issues one or two aligned memory beats per request and
// returns the extended result. Define LOAD_MISALIGNED_EN to split misaligned loads.
module load_access_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [4:0]        req_rd_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic [4:0]        rsp_rd_o,
  output logic              rsp_fault_o
);

  localparam int   BYTES   = XLEN / 8;
  localparam int   OFF_W   = $clog2(BYTES);
  localparam logic IS_RV64 = (XLEN == 64);

  load_state_e       state_q;
  load_state_e       state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic [4:0]        rd_q;
  logic              fault_q;
  logic [XLEN-1:0]   beat0_q;
  logic [XLEN-1:0]   beat1_data;
  logic [XLEN-1:0]   ext_data;
  logic [ADDR_W-1:0] beat0_addr;
  logic [OFF_W-1:0]  req_off;
  logic              req_fault;
  size_dec_t         req_dec;

`ifdef LOAD_MISALIGNED_EN
  logic              split_q;
  logic              req_split;
  logic [XLEN-1:0]   beat1_q;
`endif

  assign req_dec    = decode_size(req_funct3_i, IS_RV64);
  assign req_off    = req_addr_i[OFF_W-1:0];
  assign beat0_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

`ifdef LOAD_MISALIGNED_EN
  // A load needs a second beat when its bytes run past the end of the word.
  assign req_split  = (5'(req_off) + 5'(req_dec.size)) > 5'(BYTES);
  assign req_fault  = ~req_dec.legal;
  assign beat1_data = beat1_q;
`else
  assign req_fault  = ~req_dec.legal |
                      ((4'(req_off) & (req_dec.size - 4'd1)) != 4'd0);
  assign beat1_data = '0;
`endif

  lane_extract_extend #(
    .XLEN(XLEN)
  ) u_extract (
    .beat_pair({beat1_data, beat0_q}),
    .offset   (addr_q[OFF_W-1:0]),
    .funct3   (funct3_q),
    .data     (ext_data)
  );

  // Request fields are latched on acceptance; beats are captured on rvalid.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      fault_q  <= 1'b0;
      beat0_q  <= '0;
`ifdef LOAD_MISALIGNED_EN
      split_q  <= 1'b0;
      beat1_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i;
            funct3_q <= req_funct3_i;
            rd_q     <= req_rd_i;
            fault_q  <= req_fault;
            beat0_q  <= '0;
`ifdef LOAD_MISALIGNED_EN
            split_q  <= req_split;
            beat1_q  <= '0;
`endif
          end
        end
        S_WAIT0: begin
          if (mem_rvalid_i) beat0_q <= mem_rdata_i;
        end
`ifdef LOAD_MISALIGNED_EN
        S_WAIT1: begin
          if (mem_rvalid_i) beat1_q <= mem_rdata_i;
        end
`endif
        default: ;
      endcase
    end
  end

  // Outputs are forced to their reset values while rst_ni is low so that an
  // outstanding memory request is dropped in the same cycle.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    rsp_valid_o = 1'b0;
    rsp_data_o  = '0;
    rsp_rd_o    = '0;
    rsp_fault_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = req_fault ? S_RESP : S_REQ0;
      end
      S_REQ0: begin
        mem_req_o  = 1'b1;
        mem_addr_o = beat0_addr;
        if (mem_gnt_i) state_d = S_WAIT0;
      end
      S_WAIT0: begin
`ifdef LOAD_MISALIGNED_EN
        if (mem_rvalid_i) state_d = split_q ? S_REQ1 : S_RESP;
`else
        if (mem_rvalid_i) state_d = S_RESP;
`endif
      end
`ifdef LOAD_MISALIGNED_EN
      S_REQ1: begin
        mem_req_o  = 1'b1;
        mem_addr_o = beat0_addr + ADDR_W'(BYTES);
        if (mem_gnt_i) state_d = S_WAIT1;
      end
      S_WAIT1: begin
        if (mem_rvalid_i) state_d = S_RESP;
      end
`endif
      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_data_o  = fault_q ? '0 : ext_data;
        rsp_rd_o    = rd_q;
        rsp_fault_o = fault_q;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!rst_ni) begin
      req_ready_o = 1'b1;
      mem_req_o   = 1'b0;
      mem_addr_o  = '0;
      rsp_valid_o = 1'b0;
      rsp_data_o  = '0;
      rsp_rd_o    = '0;
      rsp_fault_o = 1'b0;
    end
  end

endmodule
